bin_to_digit_conv: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock).

---
 rtl/bin_to_digit_conv.sv | 136 +++++++++++++
 tb/tb_bin_to_digit_conv.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_digit_conv.sv
// Sequential shift-add-3 binary-to-BCD converter for the status display digits,
// with 9999 saturation, leading-zero blank mask and optional vblank-synced publish.
module bin_to_digit_conv #(
    parameter int WIDTH      = 14,
    parameter bit SYNC_VBLNK = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] value_in,
    input  logic             load_in,
    input  logic             vblnk_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             ovf_out,
    output logic [3:0]       digit3_out,
    output logic [3:0]       digit2_out,
    output logic [3:0]       digit1_out,
    output logic [3:0]       digit0_out,
    output logic [3:0]       blank_out
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SAT = WIDTH'(9999);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_VB} state_t;

    state_t           state;
    logic [WIDTH-1:0] bin;
    logic [15:0]      bcd;
    logic [CW-1:0]    cnt;
    logic             fin;
    logic             ovf_stage;
    logic             vb_q;
    logic             pub;
    logic [15:0]      bcd_adj;

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int unsigned i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [3:0] blank_of(input logic [15:0] b);
        logic [3:0] m;
        m[3] = (b[15:12] == 4'd0);
        m[2] = m[3] & (b[11:8] == 4'd0);
        m[1] = m[2] & (b[7:4] == 4'd0);
        m[0] = 1'b0;
        return m;
    endfunction

    // SHIFT spans WIDTH shift edges plus one finishing edge (fin) that hands the
    // accumulator off, giving the WIDTH+1 load-to-done latency.
    always_comb begin
        pub = 1'b0;
        if (state == SHIFT && fin && !SYNC_VBLNK)
            pub = 1'b1;
        else if (state == WAIT_VB && !load_in && vblnk_in && !vb_q)
            pub = 1'b1;
    end

    assign bcd_adj = add3(bcd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            fin       <= 1'b0;
            ovf_stage <= 1'b0;
            vb_q      <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            vb_q <= vblnk_in;
            if ((state == IDLE || state == WAIT_VB) && load_in) begin
                if (32'(value_in) > 32'd9999) begin
                    bin       <= SAT;
                    ovf_stage <= 1'b1;
                end else begin
                    bin       <= value_in;
                    ovf_stage <= 1'b0;
                end
                bcd      <= '0;
                cnt      <= CW'(WIDTH - 1);
                fin      <= 1'b0;
                busy_out <= 1'b1;
                state    <= SHIFT;
            end else begin
                case (state)
                    SHIFT: begin
                        if (fin) begin
                            fin      <= 1'b0;
                            busy_out <= 1'b0;
                            state    <= SYNC_VBLNK ? WAIT_VB : IDLE;
                        end else begin
                            bcd <= {bcd_adj[14:0], bin[WIDTH-1]};
                            bin <= {bin[WIDTH-2:0], 1'b0};
                            if (cnt == '0)
                                fin <= 1'b1;
                            else
                                cnt <= cnt - 1'b1;
                        end
                    end
                    WAIT_VB: if (pub) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_out   <= 1'b0;
            ovf_out    <= 1'b0;
            digit3_out <= '0;
            digit2_out <= '0;
            digit1_out <= '0;
            digit0_out <= '0;
            blank_out  <= 4'b1110;
        end else begin
            done_out <= pub;
            if (pub) begin
                ovf_out    <= ovf_stage;
                digit3_out <= bcd[15:12];
                digit2_out <= bcd[11:8];
                digit1_out <= bcd[7:4];
                digit0_out <= bcd[3:0];
                blank_out  <= blank_of(bcd);
            end
        end
    end
endmodule

// File: tb/tb_bin_to_digit_conv.sv
// Directed bench: one instance publishing on completion, one synced to vblank.
module tb_bin_to_digit_conv;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [13:0] value0 = '0, value1 = '0;
    logic        load0 = 1'b0, load1 = 1'b0;
    logic        vblnk0 = 1'b0, vblnk1 = 1'b0;
    logic        busy0, done0, ovf0, busy1, done1, ovf1;
    logic [3:0]  d3_0, d2_0, d1_0, d0_0, blank0;
    logic [3:0]  d3_1, d2_1, d1_1, d0_1, blank1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_digit_conv #(.WIDTH(14), .SYNC_VBLNK(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .value_in(value0), .load_in(load0), .vblnk_in(vblnk0),
        .busy_out(busy0), .done_out(done0), .ovf_out(ovf0),
        .digit3_out(d3_0), .digit2_out(d2_0), .digit1_out(d1_0), .digit0_out(d0_0),
        .blank_out(blank0)
    );

    bin_to_digit_conv #(.WIDTH(14), .SYNC_VBLNK(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .value_in(value1), .load_in(load1), .vblnk_in(vblnk1),
        .busy_out(busy1), .done_out(done1), .ovf_out(ovf1),
        .digit3_out(d3_1), .digit2_out(d2_1), .digit1_out(d1_1), .digit0_out(d0_1),
        .blank_out(blank1)
    );

    typedef struct {
        logic [13:0] value;
        logic [15:0] digits;
        logic [3:0]  blank;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse0(input logic [13:0] v);
        @(negedge clk);
        value0 = v;
        load0  = 1'b1;
        @(negedge clk);
        load0  = 1'b0;
    endtask

    task automatic pulse1(input logic [13:0] v);
        @(negedge clk);
        value1 = v;
        load1  = 1'b1;
        @(negedge clk);
        load1  = 1'b0;
    endtask

    // Negedges after the load edge until done0 is seen; -1 on timeout.
    task automatic wait_done0(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done0) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_idle1(input string name);
        int ok;
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (!busy1) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk(name, ok, 1);
    endtask

    function automatic int dig0();
        return int'({d3_0, d2_0, d1_0, d0_0});
    endfunction

    function automatic int dig1();
        return int'({d3_1, d2_1, d1_1, d0_1});
    endfunction

    initial begin
        int lat;
        int cnt;

        vecs[0]  = '{14'd1234,  16'h1234, 4'b0000, 1'b0};
        vecs[1]  = '{14'd0,     16'h0000, 4'b1110, 1'b0};
        vecs[2]  = '{14'd9999,  16'h9999, 4'b0000, 1'b0};
        vecs[3]  = '{14'd12000, 16'h9999, 4'b0000, 1'b1};
        vecs[4]  = '{14'd42,    16'h0042, 4'b1100, 1'b0};
        vecs[5]  = '{14'd7,     16'h0007, 4'b1110, 1'b0};
        vecs[6]  = '{14'd100,   16'h0100, 4'b1000, 1'b0};
        vecs[7]  = '{14'd10000, 16'h9999, 4'b0000, 1'b1};
        vecs[8]  = '{14'd16383, 16'h9999, 4'b0000, 1'b1};
        vecs[9]  = '{14'd9000,  16'h9000, 4'b0000, 1'b0};
        vecs[10] = '{14'd90,    16'h0090, 4'b1100, 1'b0};
        vecs[11] = '{14'd1005,  16'h1005, 4'b0000, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy0 | busy1), 0);
        chk("reset_done", int'(done0 | done1), 0);
        chk("reset_ovf", int'(ovf0 | ovf1), 0);
        chk("reset_digits0", dig0(), 0);
        chk("reset_digits1", dig1(), 0);
        chk("reset_blank0", int'(blank0), 4'b1110);
        chk("reset_blank1", int'(blank1), 4'b1110);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            pulse0(vecs[i].value);
            wait_done0(lat);
            chk($sformatf("latency_%0d", vecs[i].value), lat, 15);
            chk($sformatf("digits_%0d", vecs[i].value), dig0(), int'(vecs[i].digits));
            chk($sformatf("blank_%0d", vecs[i].value), int'(blank0), int'(vecs[i].blank));
            chk($sformatf("ovf_%0d", vecs[i].value), int'(ovf0), int'(vecs[i].ovf));
            @(negedge clk);
            chk($sformatf("done_one_cycle_%0d", vecs[i].value), int'(done0), 0);
        end

        // vblank-synced: result held until the vblank rising edge
        pulse1(14'd507);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done1 || dig1() != 0 || blank1 != 4'b1110) cnt++;
        end
        chk("vb_hold_unchanged", cnt, 0);
        vblnk1 = 1'b1;
        @(negedge clk);
        chk("vb_done", int'(done1), 1);
        chk("vb_digits_507", dig1(), 16'h0507);
        chk("vb_blank_507", int'(blank1), 4'b1000);
        chk("vb_ovf_507", int'(ovf1), 0);
        @(negedge clk);
        chk("vb_done_one_cycle", int'(done1), 0);
        vblnk1 = 1'b0;

        // load during SHIFT is ignored
        pulse1(14'd300);
        repeat (4) @(negedge clk);
        value1 = 14'd888;
        load1  = 1'b1;
        chk("busy_during_shift", int'(busy1), 1);
        @(negedge clk);
        load1 = 1'b0;
        wait_idle1("wait_idle_300");
        repeat (3) @(negedge clk);
        vblnk1 = 1'b1;
        @(negedge clk);
        chk("ignored_load_digits", dig1(), 16'h0300);
        vblnk1 = 1'b0;
        @(negedge clk);

        // load in WAIT_VB discards the staged result
        pulse1(14'd500);
        wait_idle1("wait_idle_500");
        pulse1(14'd77);
        chk("restart_busy", int'(busy1), 1);
        wait_idle1("wait_idle_77");
        chk("staged_not_shown", dig1(), 16'h0300);
        vblnk1 = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done1) cnt++;
        end
        chk("newest_wins_pulses", cnt, 1);
        chk("newest_wins_digits", dig1(), 16'h0077);
        chk("newest_wins_blank", int'(blank1), 4'b1100);

        // vblank already high on entry: needs a fresh rising edge
        pulse1(14'd2468);
        wait_idle1("wait_idle_2468");
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done1) cnt++;
        end
        chk("vb_high_no_publish", cnt, 0);
        chk("vb_high_digits_held", dig1(), 16'h0077);
        vblnk1 = 1'b0;
        @(negedge clk);
        vblnk1 = 1'b1;
        @(negedge clk);
        chk("vb_rerise_done", int'(done1), 1);
        chk("vb_rerise_digits", dig1(), 16'h2468);
        vblnk1 = 1'b0;

        // asynchronous reset mid-conversion
        pulse0(14'd5555);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", int'(busy0), 0);
        chk("midrst_done", int'(done0), 0);
        chk("midrst_digits", dig0(), 0);
        chk("midrst_blank", int'(blank0), 4'b1110);
        chk("midrst_ovf", int'(ovf0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done0) cnt++;
        end
        chk("midrst_no_done", cnt, 0);
        pulse0(14'd61);
        wait_done0(lat);
        chk("after_rst_latency", lat, 15);
        chk("after_rst_digits", dig0(), 16'h0061);
        chk("after_rst_blank", int'(blank0), 4'b1100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
